cpu_state_dumper: RTL
=====================

# cpu_state_dumper

On-chip state dumper for the five-stage pipelined CPU. It keeps hardware cycle, stall and flush counters and, on request, freezes the core. It then streams a fixed-order snapshot out over a valid/ready port: counters, PC, all 32 registers and data memory 0x00–0x1C. It sits beside CPU, tapping the register file and data memory read ports, and gives the same per-cycle visibility in silicon that simulation gets from hierarchical probes.

## Interface
- NUM_REGS, 32, register-file entries dumped
- NUM_MEM_WORDS, 8, 32-bit data-memory words dumped from address 0
- CNT_W, 32, width of cycle/stall/flush counters
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  CPU run enable; counters advance only when high
- stall_i  in  1  hazard-unit stall, sampled each cycle
- flush_i  in  1  branch-taken flush (MEM-stage PCSrc), sampled each cycle
- pc_i  in  32  current PC
- dump_req_i  in  1  single-cycle dump request
- hold_o  out  1  freeze request to CPU; PC and pipeline registers hold while high
- busy_o  out  1  dump in progress
- reg_addr_o  out  5  register-file read address
- reg_data_i  in  32  register-file read data, combinational from reg_addr_o
- mem_addr_o  out  32  data-memory byte address, word aligned
- mem_data_i  in  32  data-memory read data, little-endian word, combinational
- out_valid_o  out  1  beat valid
- out_ready_i  in  1  sink ready
- out_tag_o  out  8  beat identifier
- out_data_o  out  32  beat payload
- cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  CNT_W  live counter values

## Operation
- Counters
  - cycle_cnt increments each cycle with start_i=1 and hold_o=0.
  - stall_cnt and flush_cnt increment under the same gate when stall_i or flush_i is high. Both increment if both are high.
  - All counters wrap modulo 2^CNT_W.
- FSM states: IDLE, FREEZE, SEND.
  - IDLE → FREEZE on dump_req_i.
  - FREEZE → SEND after exactly one cycle. This lets the in-flight write-back commit.
  - SEND → IDLE when the last beat is accepted.
- Snapshot: counters and PC are captured into shadow registers on the FREEZE cycle.
- Beat order: beat index 0..43, 6-bit counter.
  - 0: tag 0xF0, cycle count
  - 1: tag 0xF1, stall count
  - 2: tag 0xF2, flush count
  - 3: tag 0xF3, PC
  - 4..35: tag 0x00+i, register xi, with reg_addr_o=i
  - 36..43: tag 0x20+j, memory word j, with mem_addr_o=4j
- reg_addr_o and mem_addr_o are 0 outside SEND.
- hold_o = busy_o = (state != IDLE).
- dump_req_i while busy is ignored, not queued.
- x0 is dumped as read; no forcing to zero inside this block.

## Timing
- Reset values: state IDLE, all counters 0, hold_o=0, busy_o=0, out_valid_o=0, out_tag_o=0, out_data_o=0, beat index 0.
- dump_req_i high in cycle N gives hold_o=1 in N+1 and out_valid_o=1 with beat 0 in N+2.
- Output is a registered skid-free stage. A new beat loads when out_valid_o=0 or (out_valid_o and out_ready_i).
- Tag and data stay stable while valid=1 and ready=0.
- With out_ready_i held high, one beat per cycle. The full dump takes 44 cycles after first valid.
- Last beat accepted in cycle M: out_valid_o=0, hold_o=0 and state IDLE in M+1. Counters resume in M+1.
- A dump_req_i in the same cycle as the last acceptance is ignored.
- rst_i mid-dump: the next cycle is IDLE with all outputs at reset values. There is no partial-frame completion.
- rst_i wins over dump_req_i in the same cycle.

## Structure
- The shared package cpu_dbg_pkg holds:
  - tag constants TAG_CYCLE=8'hF0, TAG_STALL=8'hF1, TAG_FLUSH=8'hF2, TAG_PC=8'hF3, TAG_REG_BASE=8'h00, TAG_MEM_BASE=8'h20
  - the FSM state enum
  - DUMP_BEATS=44
- One natural sub-module, perf_counters: the three gated wrap-around counters plus snapshot capture. It is instantiated once.
- Beat sequencing and the handshake stay in the top.

## Test plan
- Reset, then 10 cycles with start_i=1, stall_i pulsed in 2 cycles and flush_i in 1 → counters read 10/2/1, and hold_o and out_valid_o stay 0 throughout.
- Preload x5=7 and mem word 0=5, set pc_i=0x40 and issue dump_req_i with ready tied high:
  - beats 0xF0..0xF3 carry the snapshot counts and 0x40
  - the beat tagged 0x05 carries 7
  - the beat tagged 0x20 carries 5
  - the 44 beats are contiguous
- Random out_ready_i backpressure during a dump → no beat dropped or duplicated, and tag/data stay stable while valid and not ready.
- stall_i and flush_i high in the same cycle → both counters +1. Counter preloaded to 0xFFFFFFFF → wraps to 0 on the next increment.
- dump_req_i reasserted mid-dump → ignored. Exactly 44 beats, then IDLE.
- rst_i asserted at beat 20 → out_valid_o=0, hold_o=0 and counters 0 the next cycle. A fresh dump then starts at tag 0xF0.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU state dumper: beat tags, FSM states and frame length.
package cpu_dbg_pkg;

    localparam logic [7:0] TAG_CYCLE    = 8'hF0;
    localparam logic [7:0] TAG_STALL    = 8'hF1;
    localparam logic [7:0] TAG_FLUSH    = 8'hF2;
    localparam logic [7:0] TAG_PC       = 8'hF3;
    localparam logic [7:0] TAG_REG_BASE = 8'h00;
    localparam logic [7:0] TAG_MEM_BASE = 8'h20;

    localparam int DUMP_BEATS = 44;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FREEZE = 2'd1,
        ST_SEND   = 2'd2
    } dump_state_e;

endpackage

// File: rtl/perf_counters.sv
// Gated wrap-around cycle/stall/flush counters with a shadow snapshot of the
// counters and PC taken while the core is frozen.
module perf_counters
    import cpu_dbg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             capture_i,
    input  logic [31:0]      pc_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] cycle_snap_o,
    output logic [CNT_W-1:0] stall_snap_o,
    output logic [CNT_W-1:0] flush_snap_o,
    output logic [31:0]      pc_snap_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] cycle_q, cycle_d, stall_q, stall_d, flush_q, flush_d;
    logic [CNT_W-1:0] cycle_snap_q, cycle_snap_d, stall_snap_q, stall_snap_d;
    logic [CNT_W-1:0] flush_snap_q, flush_snap_d;
    logic [31:0]      pc_snap_q, pc_snap_d;

    // Next-state for the live counters; all wrap naturally at 2^CNT_W.
    always_comb begin
        cycle_d = cycle_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (en_i) begin
            cycle_d = cycle_q + CNT_ONE;
            if (stall_i) begin
                stall_d = stall_q + CNT_ONE;
            end else begin
                stall_d = stall_q;
            end
            if (flush_i) begin
                flush_d = flush_q + CNT_ONE;
            end else begin
                flush_d = flush_q;
            end
        end else begin
            cycle_d = cycle_q;
        end
    end

    // Next-state for the snapshot shadows.
    always_comb begin
        cycle_snap_d = cycle_snap_q;
        stall_snap_d = stall_snap_q;
        flush_snap_d = flush_snap_q;
        pc_snap_d    = pc_snap_q;
        if (capture_i) begin
            cycle_snap_d = cycle_q;
            stall_snap_d = stall_q;
            flush_snap_d = flush_q;
            pc_snap_d    = pc_i;
        end else begin
            pc_snap_d    = pc_snap_q;
        end
    end

    // Counter and shadow registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q      <= '0;
            stall_q      <= '0;
            flush_q      <= '0;
            cycle_snap_q <= '0;
            stall_snap_q <= '0;
            flush_snap_q <= '0;
            pc_snap_q    <= 32'd0;
        end else begin
            cycle_q      <= cycle_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
            cycle_snap_q <= cycle_snap_d;
            stall_snap_q <= stall_snap_d;
            flush_snap_q <= flush_snap_d;
            pc_snap_q    <= pc_snap_d;
        end
    end

    assign cycle_cnt_o  = cycle_q;
    assign stall_cnt_o  = stall_q;
    assign flush_cnt_o  = flush_q;
    assign cycle_snap_o = cycle_snap_q;
    assign stall_snap_o = stall_snap_q;
    assign flush_snap_o = flush_snap_q;
    assign pc_snap_o    = pc_snap_q;

endmodule

// File: rtl/cpu_state_dumper.sv
// Freezes the core on request and streams counters, PC, register file and the
// low data-memory words as tagged beats over a registered valid/ready port.
module cpu_state_dumper
    import cpu_dbg_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_WORDS = 8,
    parameter int CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      pc_i,
    input  logic             dump_req_i,
    output logic             hold_o,
    output logic             busy_o,
    output logic [4:0]       reg_addr_o,
    input  logic [31:0]      reg_data_i,
    output logic [31:0]      mem_addr_o,
    input  logic [31:0]      mem_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [7:0]       out_tag_o,
    output logic [31:0]      out_data_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [5:0] BEAT_REG0 = 6'd4;
    localparam logic [5:0] BEAT_MEM0 = 6'(4 + NUM_REGS);
    localparam logic [5:0] BEAT_END  = 6'(4 + NUM_REGS + NUM_MEM_WORDS);

    dump_state_e state_q, state_d;
    logic [5:0]  beat_q, beat_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_tag_q, out_tag_d;
    logic [31:0] out_data_q, out_data_d;

    logic             busy, capture, accept, slot_free, load_beat, last_accept;
    logic [5:0]       beat_off;
    logic [7:0]       beat_tag;
    logic [31:0]      beat_data;
    logic [CNT_W-1:0] cycle_snap, stall_snap, flush_snap;
    logic [31:0]      pc_snap;

    assign busy        = (state_q != ST_IDLE);
    assign capture     = (state_q == ST_FREEZE);
    assign accept      = out_valid_q & out_ready_i;
    assign slot_free   = ~out_valid_q | out_ready_i;
    assign load_beat   = busy & slot_free & (beat_q != BEAT_END);
    assign last_accept = (state_q == ST_SEND) & accept & (beat_q == BEAT_END);

    perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf_counters (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (start_i & ~busy),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .capture_i   (capture),
        .pc_i        (pc_i),
        .cycle_cnt_o (cycle_cnt_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o),
        .cycle_snap_o(cycle_snap),
        .stall_snap_o(stall_snap),
        .flush_snap_o(flush_snap),
        .pc_snap_o   (pc_snap)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; requests arriving while busy are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dump_req_i) begin
                    state_d = ST_FREEZE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FREEZE: state_d = ST_SEND;
            ST_SEND: begin
                if (last_accept) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat decode: tag, payload and read addresses for the next beat to load.
    // Beat 0 is loaded in FREEZE, before the shadows hold it, so it uses the
    // (already frozen) live cycle count.
    always_comb begin
        beat_off   = 6'd0;
        beat_tag   = 8'd0;
        beat_data  = 32'd0;
        reg_addr_o = 5'd0;
        mem_addr_o = 32'd0;
        if (beat_q < BEAT_REG0) begin
            case (beat_q[1:0])
                2'd0: begin
                    beat_tag  = TAG_CYCLE;
                    beat_data = 32'(capture ? cycle_cnt_o : cycle_snap);
                end
                2'd1: begin
                    beat_tag  = TAG_STALL;
                    beat_data = 32'(stall_snap);
                end
                2'd2: begin
                    beat_tag  = TAG_FLUSH;
                    beat_data = 32'(flush_snap);
                end
                default: begin
                    beat_tag  = TAG_PC;
                    beat_data = pc_snap;
                end
            endcase
        end else if (beat_q < BEAT_MEM0) begin
            beat_off  = beat_q - BEAT_REG0;
            beat_tag  = TAG_REG_BASE + {2'b00, beat_off};
            beat_data = reg_data_i;
            if (state_q == ST_SEND) begin
                reg_addr_o = beat_off[4:0];
            end else begin
                reg_addr_o = 5'd0;
            end
        end else if (beat_q < BEAT_END) begin
            beat_off  = beat_q - BEAT_MEM0;
            beat_tag  = TAG_MEM_BASE + {2'b00, beat_off};
            beat_data = mem_data_i;
            if (state_q == ST_SEND) begin
                mem_addr_o = {24'd0, beat_off, 2'b00};
            end else begin
                mem_addr_o = 32'd0;
            end
        end else begin
            beat_tag  = 8'd0;
        end
    end

    // Output stage next-state: load into a free slot, else drain on accept.
    always_comb begin
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_data_d  = out_data_q;
        beat_d      = beat_q;
        if (load_beat) begin
            out_valid_d = 1'b1;
            out_tag_d   = beat_tag;
            out_data_d  = beat_data;
            beat_d      = beat_q + 6'd1;
        end else if (accept) begin
            out_valid_d = 1'b0;
            beat_d      = last_accept ? 6'd0 : beat_q;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output stage and beat index registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= 8'd0;
            out_data_q  <= 32'd0;
            beat_q      <= 6'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_data_q  <= out_data_d;
            beat_q      <= beat_d;
        end
    end

    assign hold_o      = busy;
    assign busy_o      = busy;
    assign out_valid_o = out_valid_q;
    assign out_tag_o   = out_tag_q;
    assign out_data_o  = out_data_q;

endmodule
